// File: rtl/bsg_link_packet_serializer.sv
// Splits one wide message into width_p-bit flits, LSB word first. It holds one message and sends the next one without a gap.
// Defining BSG_LINK_PACKET_SERIALIZER_STATS_EN adds saturating message and stall counters.
module bsg_link_packet_serializer #(
    parameter int msg_width_p = 128,
    parameter int width_p     = 32
) (
    input  logic                   core_clk_i,
    input  logic                   core_reset_n_i,
    input  logic                   msg_v_i,
    input  logic [msg_width_p-1:0] msg_data_i,
    output logic                   msg_ready_and_o,
    output logic                   flit_v_o,
    output logic [width_p-1:0]     flit_data_o,
    input  logic                   flit_ready_and_i,
    output logic                   busy_o
`ifdef BSG_LINK_PACKET_SERIALIZER_STATS_EN
    ,
    output logic [31:0]            stat_msgs_o,
    output logic [31:0]            stat_stalls_o
`endif
);

    localparam int num_flits_lp = (msg_width_p + width_p - 1) / width_p;
    localparam int cnt_width_lp = (num_flits_lp > 1) ? $clog2(num_flits_lp) : 1;
    localparam int buf_width_lp = num_flits_lp * width_p;
    localparam logic [cnt_width_lp-1:0] last_cnt_lp = cnt_width_lp'(num_flits_lp - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e                  full_r;
    logic [buf_width_lp-1:0] msg_r;
    logic [cnt_width_lp-1:0] cnt_r;
    logic                    last;
    logic                    flit_xfer;
    logic                    msg_accept;

    assign last            = (full_r == FULL) && (cnt_r == last_cnt_lp);
    assign flit_xfer       = (full_r == FULL) && flit_ready_and_i;
    // Accepting while the last flit leaves keeps the stream gap-free.
    assign msg_ready_and_o = (full_r == EMPTY) || (last && flit_ready_and_i);
    assign msg_accept      = msg_v_i && msg_ready_and_o;
    assign flit_v_o        = (full_r == FULL);
    assign busy_o          = (full_r == FULL);

    generate
        if (num_flits_lp == 1) begin : g_single
            assign flit_data_o = msg_r;
        end else begin : g_multi
            logic [num_flits_lp-1:0][width_p-1:0] msg_words;
            assign msg_words   = msg_r;
            assign flit_data_o = msg_words[cnt_r];
        end
    endgenerate

    // NOTE: the payload register is reset too, so flit_data_o reads 0 while in reset.
    always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
        if (!core_reset_n_i) begin
            full_r <= EMPTY;
            cnt_r  <= '0;
            msg_r  <= '0;
        end else if (msg_accept) begin
            full_r <= FULL;
            cnt_r  <= '0;
            msg_r  <= buf_width_lp'(msg_data_i);
        end else if (flit_xfer) begin
            if (last) begin
                full_r <= EMPTY;
                cnt_r  <= '0;
            end else begin
                cnt_r  <= cnt_r + cnt_width_lp'(1);
            end
        end
    end

`ifdef BSG_LINK_PACKET_SERIALIZER_STATS_EN
    logic [31:0] stat_msgs_r;
    logic [31:0] stat_stalls_r;
    logic        stall;

    assign stall = (full_r == FULL) && !flit_ready_and_i;

    always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
        if (!core_reset_n_i) begin
            stat_msgs_r   <= '0;
            stat_stalls_r <= '0;
        end else begin
            if (flit_xfer && last && (stat_msgs_r != '1)) stat_msgs_r <= stat_msgs_r + 32'd1;
            if (stall && (stat_stalls_r != '1)) stat_stalls_r <= stat_stalls_r + 32'd1;
        end
    end

    assign stat_msgs_o   = stat_msgs_r;
    assign stat_stalls_o = stat_stalls_r;
`endif

endmodule

// File: tb/tb_bsg_link_packet_serializer.sv
// Scoreboard bench for bsg_link_packet_serializer: a 128/32 instance, a 72/32 instance and a 32/32 instance.
// Stats checks are compiled in when BSG_LINK_PACKET_SERIALIZER_STATS_EN is defined.
module tb_bsg_link_packet_serializer;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Main instance, 128/32
    logic         msg_v, msg_rdy, flit_v, flit_rdy, busy;
    logic [127:0] msg_data;
    logic [31:0]  flit_data;
`ifdef BSG_LINK_PACKET_SERIALIZER_STATS_EN
    logic [31:0]  stat_msgs, stat_stalls;
`endif

    bsg_link_packet_serializer #(.msg_width_p(128), .width_p(32)) u_dut (
        .core_clk_i      (clk),
        .core_reset_n_i  (rst_n),
        .msg_v_i         (msg_v),
        .msg_data_i      (msg_data),
        .msg_ready_and_o (msg_rdy),
        .flit_v_o        (flit_v),
        .flit_data_o     (flit_data),
        .flit_ready_and_i(flit_rdy),
        .busy_o          (busy)
`ifdef BSG_LINK_PACKET_SERIALIZER_STATS_EN
        ,
        .stat_msgs_o     (stat_msgs),
        .stat_stalls_o   (stat_stalls)
`endif
    );

    // Non-multiple width, 72/32
    logic        m72_v, m72_rdy, f72_v, f72_rdy, b72;
    logic [71:0] m72_data;
    logic [31:0] f72_data;
`ifdef BSG_LINK_PACKET_SERIALIZER_STATS_EN
    logic [31:0] s72_msgs, s72_stalls;
`endif

    bsg_link_packet_serializer #(.msg_width_p(72), .width_p(32)) u_dut72 (
        .core_clk_i      (clk),
        .core_reset_n_i  (rst_n),
        .msg_v_i         (m72_v),
        .msg_data_i      (m72_data),
        .msg_ready_and_o (m72_rdy),
        .flit_v_o        (f72_v),
        .flit_data_o     (f72_data),
        .flit_ready_and_i(f72_rdy),
        .busy_o          (b72)
`ifdef BSG_LINK_PACKET_SERIALIZER_STATS_EN
        ,
        .stat_msgs_o     (s72_msgs),
        .stat_stalls_o   (s72_stalls)
`endif
    );

    // Single flit, 32/32
    logic        m32_v, m32_rdy, f32_v, f32_rdy, b32;
    logic [31:0] m32_data;
    logic [31:0] f32_data;
`ifdef BSG_LINK_PACKET_SERIALIZER_STATS_EN
    logic [31:0] s32_msgs, s32_stalls;
`endif

    bsg_link_packet_serializer #(.msg_width_p(32), .width_p(32)) u_dut32 (
        .core_clk_i      (clk),
        .core_reset_n_i  (rst_n),
        .msg_v_i         (m32_v),
        .msg_data_i      (m32_data),
        .msg_ready_and_o (m32_rdy),
        .flit_v_o        (f32_v),
        .flit_data_o     (f32_data),
        .flit_ready_and_i(f32_rdy),
        .busy_o          (b32)
`ifdef BSG_LINK_PACKET_SERIALIZER_STATS_EN
        ,
        .stat_msgs_o     (s32_msgs),
        .stat_stalls_o   (s32_stalls)
`endif
    );

    logic [31:0] q_main[$];
    logic [31:0] q72[$];
    logic [31:0] q32[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors: pop an expected flit whenever a transfer is presented
    logic        hold_pending = 1'b0;
    logic [31:0] held_data;
    int          stall_seen = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (hold_pending && flit_v) check("stall_hold", flit_data, held_data);
            hold_pending = 1'b0;
            check("busy_eq_v", busy, flit_v);
            if (flit_v && flit_rdy) begin
                if (q_main.size() == 0) check("main_spurious_flit", flit_data, 128'hx);
                else check("main_flit", flit_data, q_main.pop_front());
            end else if (flit_v) begin
                hold_pending = 1'b1;
                held_data    = flit_data;
                stall_seen++;
            end
        end else begin
            hold_pending = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n && f72_v && f72_rdy) begin
            if (q72.size() == 0) check("f72_spurious_flit", f72_data, 128'hx);
            else check("f72_flit", f72_data, q72.pop_front());
        end
    end

    always @(negedge clk) begin
        if (rst_n && f32_v && f32_rdy) begin
            if (q32.size() == 0) check("f32_spurious_flit", f32_data, 128'hx);
            else check("f32_flit", f32_data, q32.pop_front());
        end
    end

    // Offers d to the main instance, waits (bounded) for acceptance, pushes the four expected words.
    task automatic send_main(input logic [127:0] d, output int acc_cyc);
        int n = 0;
        msg_v    = 1'b1;
        msg_data = d;
        do begin
            @(negedge clk);
            n++;
        end while (!msg_rdy && n < 50);
        if (!msg_rdy) check("accept_timeout", 0, 1);
        acc_cyc = cyc;
        @(posedge clk);
        for (int k = 0; k < 4; k++) q_main.push_back(d[k*32 +: 32]);
        #1;
        msg_v = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, a2, base;
        rst_n = 1'b0;
        msg_v = 1'b0; msg_data = '0; flit_rdy = 1'b1;
        m72_v = 1'b0; m72_data = '0; f72_rdy = 1'b1;
        m32_v = 1'b0; m32_data = '0; f32_rdy = 1'b1;
        #12;
        check("rst_flit_v", flit_v, 0);
        check("rst_flit_data", flit_data, 0);
        check("rst_busy", busy, 0);
        check("rst_msg_ready", msg_rdy, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Back-to-back: accepts exactly every 4th cycle, then drains in 12 cycles
        send_main(128'h03030303_02020202_01010101_00000000, a0);
        send_main(128'h13131313_12121212_11111111_10101010, a1);
        send_main(128'h23232323_22222222_21212121_20202020, a2);
        check("b2b_accept_gap1", a1 - a0, 4);
        check("b2b_accept_gap2", a2 - a1, 4);
        repeat (4) @(posedge clk);
        #1;
        check("b2b_idle_after", flit_v, 0);
        check("b2b_queue_drained", q_main.size(), 0);

        // Backpressure: ready pattern 1,0,0 repeating gives 6 stall cycles across 4 flits
        send_main(128'h44443333_22221111_00FF00FF_A5A5C3C3, a0);
        base = stall_seen;
        for (int j = 0; j < 10; j++) begin
            flit_rdy = (j % 3 == 0);
            @(posedge clk); #1;
        end
        flit_rdy = 1'b1;
        check("bp_idle_after", flit_v, 0);
        check("bp_queue_drained", q_main.size(), 0);
        check("bp_stall_cycles", stall_seen - base, 6);
`ifdef BSG_LINK_PACKET_SERIALIZER_STATS_EN
        check("stat_stalls", stat_stalls, 6);
        check("stat_msgs", stat_msgs, 4);
`endif

        // Reset after flit 1 of 4: outputs clear before the next edge
        send_main(128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000, a0);
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_flit2", flit_data, 32'hCCCC0002);
        rst_n = 1'b0;
        #1;
        check("async_rst_flit_v", flit_v, 0);
        check("async_rst_flit_data", flit_data, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_msg_ready", msg_rdy, 1);
`ifdef BSG_LINK_PACKET_SERIALIZER_STATS_EN
        check("rst_stat_msgs", stat_msgs, 0);
        check("rst_stat_stalls", stat_stalls, 0);
`endif
        q_main.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_main(128'h77770003_66660002_55550001_44440000, a0);
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_idle", flit_v, 0);
        check("post_rst_queue_drained", q_main.size(), 0);

        // Non-multiple width: top flit is zero-extended
        m72_v    = 1'b1;
        m72_data = 72'hAB_12345678_9ABCDEF0;
        @(negedge clk);
        check("f72_ready", m72_rdy, 1);
        @(posedge clk);
        q72.push_back(32'h9ABCDEF0);
        q72.push_back(32'h12345678);
        q72.push_back(32'h000000AB);
        #1;
        m72_v    = 1'b0;
        m72_data = 72'hFF_FFFFFFFF_FFFFFFFF;
        repeat (3) @(posedge clk);
        #1;
        check("f72_idle_after", f72_v, 0);
        check("f72_queue_drained", q72.size(), 0);

        // Single flit: msg_v held high, one accept and one flit every cycle
        m32_v = 1'b1;
        for (int i = 0; i < 5; i++) begin
            m32_data = 32'hC0DE0000 + 32'(i);
            @(negedge clk);
            check("f32_ready", m32_rdy, 1);
            if (i > 0) check("f32_streaming", f32_v, 1);
            @(posedge clk);
            q32.push_back(32'hC0DE0000 + 32'(i));
            #1;
        end
        m32_v = 1'b0;
        @(negedge clk);
        check("f32_last_latency", f32_data, 32'hC0DE0004);
        @(posedge clk); #1;
        check("f32_idle_after", f32_v, 0);
        check("f32_queue_drained", q32.size(), 0);

`ifdef BSG_LINK_PACKET_SERIALIZER_STATS_EN
        // Saturation of the message counter
        u_dut.stat_msgs_r = 32'hFFFF_FFFE;
        send_main(128'h1, a0);
        send_main(128'h2, a1);
        send_main(128'h3, a2);
        repeat (5) @(posedge clk);
        #1;
        check("stat_msgs_saturate", stat_msgs, 32'hFFFF_FFFF);
`endif

        repeat (2) @(posedge clk);
        #1;
        check("final_main_queue", q_main.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
